// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the sequential BCD-to-binary converter.
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN (adds the invalid-digit helper).
package bcd_pkg;

  localparam int unsigned BIN_W        = 14;
  localparam int unsigned BCD_DIGITS   = 4;
  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned BCD_W        = BCD_DIGITS * DIGIT_W;
  localparam int unsigned SHIFT_CYCLES = 14;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  // True when every packed BCD digit is in 0..9.
  function automatic logic bcd_all_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction
`endif

endpackage

// File: rtl/bcd_digit_sub3.sv
// One-digit correction step for reverse double-dabble.
// Ports: din (4-bit digit after shift), dout (din-3 when din>=8, else din).
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= DIGIT_W'(8)) ? (din - DIGIT_W'(3)) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble, one bit per cycle).
// Ports: clk, rst (sync, active-high), start, thousands/hundreds/tens/ones (BCD digits),
//        bin (registered result), busy, done (one-cycle pulse), err (only with BCD2BIN_DIGIT_CHECK_EN).
// Macro BCD2BIN_DIGIT_CHECK_EN: reject digits >9 with an immediate err/done and bin=0.
module bcd2bin_seq
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIGIT_W-1:0] thousands,
  input  logic [DIGIT_W-1:0] hundreds,
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done
`ifdef BCD2BIN_DIGIT_CHECK_EN
  ,
  output logic               err
`endif
);

  state_t               state, state_next;
  logic [BCD_W-1:0]     bcd_reg;
  logic [BIN_W-1:0]     shift_reg;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W-1:0]     digits;
  logic [BCD_W+BIN_W-1:0] cat_sh;
  logic [BCD_W-1:0]     bcd_sh;
  logic [BCD_W-1:0]     bcd_next;
  logic [BIN_W-1:0]     shift_next;
  logic                 accept;
  logic                 last_shift;
  logic                 busy_d;
  logic                 done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic                 bad_q;
  logic                 err_d;
`endif

  assign digits = {thousands, hundreds, tens, ones};

  // Shift the combined register right; the BCD LSB moves into the binary MSB.
  assign cat_sh     = {bcd_reg, shift_reg} >> 1;
  assign bcd_sh     = cat_sh[BIN_W +: BCD_W];
  assign shift_next = cat_sh[BIN_W-1:0];

  // Per-digit correction after the shift.
  for (genvar g = 0; g < int'(BCD_DIGITS); g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .din  (bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_next[g*DIGIT_W +: DIGIT_W])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
          state_next = bcd_all_valid(digits) ? ST_SHIFT : ST_DONE;
`else
          state_next = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: if (last_shift) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output/control decode; done and err lag the DONE state by one registered cycle.
  always_comb begin
    accept     = (state == ST_IDLE) && start;
    last_shift = (state == ST_SHIFT) && (cnt == CNT_W'(SHIFT_CYCLES - 1));
    busy_d     = (state_next != ST_IDLE);
    done_d     = (state == ST_DONE);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_d      = (state == ST_DONE) && bad_q;
`endif
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg   <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      bin       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_q     <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      busy <= busy_d;
      done <= done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err  <= err_d;
`endif
      if (accept) begin
        bcd_reg   <= digits;
        shift_reg <= '0;
        cnt       <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad_q     <= !bcd_all_valid(digits);
`endif
      end else if (state == ST_SHIFT) begin
        bcd_reg   <= bcd_next;
        shift_reg <= shift_next;
        cnt       <= cnt + CNT_W'(1);
      end
      if (last_shift) bin <= shift_next;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      if ((state == ST_DONE) && bad_q) bin <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: vector table plus reset, busy-start and back-to-back sequences.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic [13:0] bin;
  logic        busy;
  logic        done;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcd2bin_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .bin       (bin),
    .busy      (busy),
    .done      (done)
`ifdef BCD2BIN_DIGIT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  th, hu, te, on;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One start pulse; waits (bounded) for done, checks latency, busy window, result and err.
  task automatic convert(input logic [3:0] th, hu, te, on, input int exp_bin,
                         input int exp_lat, input int exp_err, input string name);
    int k;
    bit busy_ok;
    @(negedge clk);
    thousands = th; hundreds = hu; tens = te; ones = on; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    while (!done && k < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, exp_lat);
    check({name, "_bin"}, int'(bin), exp_bin);
    check({name, "_busy_window"}, int'(busy_ok), 1);
    check({name, "_busy_low_at_done"}, int'(busy), 0);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    check({name, "_err"}, int'(err), exp_err);
`else
    if (exp_err != 0) check({name, "_err_unexpected"}, 0, exp_err);
`endif
    @(negedge clk);
    check({name, "_done_one_cycle"}, int'(done), 0);
  endtask

  function automatic int fdig(input int j, input int sel);
    case (sel)
      0: return j % 10;
      1: return (j + 3) % 10;
      2: return (j * 7) % 10;
      default: return (j + 1) % 10;
    endcase
  endfunction

  function automatic int fval(input int j);
    return 1000 * fdig(j, 0) + 100 * fdig(j, 1) + 10 * fdig(j, 2) + fdig(j, 3);
  endfunction

  initial begin
    int k;
    int ndone;
    int last_acc;

    vecs[0] = '{4'd9, 4'd9, 4'd9, 4'd9, 14'd9999};
    vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 14'd0};
    vecs[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 14'd1234};
    vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd9, 14'd9};
    vecs[4] = '{4'd5, 4'd0, 4'd0, 4'd0, 14'd5000};
    vecs[5] = '{4'd8, 4'd4, 4'd2, 4'd1, 14'd8421};
    vecs[6] = '{4'd7, 4'd3, 4'd0, 4'd5, 14'd7305};
    vecs[7] = '{4'd1, 4'd0, 4'd9, 4'd0, 14'd1090};

    rst = 1'b1; start = 1'b0;
    thousands = '0; hundreds = '0; tens = '0; ones = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_bin", int'(bin), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    foreach (vecs[i])
      convert(vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].on, int'(vecs[i].exp), 16, 0,
              $sformatf("vec%0d", i));

    // Reset during the seventh shift cycle aborts without a done pulse.
    @(negedge clk);
    thousands = 4'd3; hundreds = 4'd3; tens = 4'd3; ones = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_bin", int'(bin), 0);
    check("midrst_done", int'(done), 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    convert(4'd4, 4'd0, 4'd9, 4'd6, 4096, 16, 0, "after_rst");

    // Start pulsed while busy is ignored.
    @(negedge clk);
    thousands = 4'd1; hundreds = 4'd2; tens = 4'd3; ones = 4'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    thousands = 4'd9; hundreds = 4'd8; tens = 4'd7; ones = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    k = 6;
    while (k < 45) begin
      if (done) begin
        ndone++;
        check("busystart_latency", k, 16);
        check("busystart_bin", int'(bin), 1234);
      end
      @(negedge clk);
      k++;
    end
    check("busystart_one_done", ndone, 1);

    // Start held high with digits changing every cycle: one conversion per 16 cycles.
    ndone = 0;
    last_acc = 0;
    for (int j = 0; j <= 50; j++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("b2b_spacing", j - last_acc, 16);
        check("b2b_bin", int'(bin), fval(last_acc));
        last_acc = j;
      end
      thousands = 4'(fdig(j, 0)); hundreds = 4'(fdig(j, 1));
      tens = 4'(fdig(j, 2)); ones = 4'(fdig(j, 3));
      start = 1'b1;
    end
    check("b2b_done_count", ndone, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    convert(4'd0, 4'hA, 4'd0, 4'd0, 0, 2, 1, "invalid");
    convert(4'd5, 4'd0, 4'd0, 4'd0, 5000, 16, 0, "valid_after_invalid");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
Parameters: none; widths come from shared package constants (REQ-023).
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 thousands  input  4  BCD digit, weight 1000; captured on accepted start.
REQ-005 hundreds  input  4  BCD digit, weight 100; captured on accepted start.
REQ-006 tens  input  4  BCD digit, weight 10; captured on accepted start.
REQ-007 ones  input  4  BCD digit, weight 1; captured on accepted start.
REQ-008 bin  output  14  binary result, registered; held until the next done.
REQ-009 busy  output  1  high in SHIFT and DONE states.
REQ-010 done  output  1  one-cycle pulse; bin valid in the same cycle.
REQ-011 err  output  1  invalid-digit flag; port exists only with BCD2BIN_DIGIT_CHECK_EN.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE; the state SHALL be IDLE after reset.
REQ-013 In IDLE with start=1, the block SHALL capture the four digits into a 16-bit BCD register, clear the 14-bit shift register, clear the 4-bit counter, and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL right-shift {bcd_reg, shift_reg} by one bit; then, for each BCD digit whose shifted value is >=8, it SHALL subtract 3 from that digit (reverse double-dabble).
REQ-015 After the 14th SHIFT cycle (counter==13), the block SHALL load bin from shift_reg and enter DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-017 Latency: if start is accepted at edge N, done SHALL be high during the cycle after edge N+15. A new start SHALL be accepted no earlier than edge N+16.
REQ-018 start SHALL be ignored while busy=1; captured digits SHALL NOT change during a conversion.
REQ-019 For valid inputs, the result SHALL equal 1000*thousands + 100*hundreds + 10*tens + ones (range 0..9999). The 14-bit width SHALL hold this range without overflow.
REQ-020 Holding start high continuously SHALL produce one conversion per 16 cycles, using the digits present at each accepting edge.

Reset
REQ-021 With rst=1 at a clock edge: state SHALL go to IDLE, and bin, busy, done, err, the counter and all internal registers SHALL go to 0.
REQ-022 Reset in mid-conversion SHALL abort the conversion with no done pulse; bin SHALL read 0.

Configuration
REQ-023 Macro BCD2BIN_DIGIT_CHECK_EN defined: on an accepted start with any digit >9, the block SHALL skip SHIFT and go directly to DONE (done one cycle after the accepting edge +1), with err=1 and bin=0. err SHALL be 1 only during that done cycle; valid conversions SHALL report err=0.
REQ-024 Macro undefined: the err port and all check logic SHALL be absent. Invalid digits SHALL convert through the normal 14-cycle path, and bin is unspecified but deterministic.

Structure
REQ-025 A shared package bcd_pkg SHALL hold BIN_W=14, BCD_DIGITS=4, DIGIT_W=4, SHIFT_CYCLES=14 and the state encoding constants.
REQ-026 One sub-module, bcd_digit_sub3 (4-bit combinational: out = in>=8 ? in-3 : in), SHALL be instantiated once per digit.

Verification
REQ-027 Digits 9,9,9,9 with a start pulse -> done after 16 cycles, bin=9999 (0x270F), busy high throughout.
REQ-028 Digits 0,0,0,0 -> bin=0; digits 1,2,3,4 -> bin=1234 (0x4D2); digits 0,0,0,9 -> bin=9.
REQ-029 start held high with digits changed every cycle -> done pulses exactly 16 cycles apart; each result matches the digits sampled at the accepting edge.
REQ-030 rst asserted at SHIFT cycle 7 -> next cycle busy=0, bin=0, no done; a following start converts correctly.
REQ-031 With BCD2BIN_DIGIT_CHECK_EN, digits 0,0xA,0,0 -> done 2 cycles after start, err=1, bin=0; then 5,0,0,0 -> bin=5000, err=0.
REQ-032 start pulsed during busy -> ignored; exactly one done pulse, and the result reflects the original digits.
